// File: rtl/pc_3gpp_dec_source.sv
// Input framing for the PC 3GPP decoder: streams sop/val/eop LLRs into one pN_MAX-entry buffer bank.
// Writes appear 1 cycle after accept; short frames are zero-padded, long ones truncated, both flag oerr.
module pc_3gpp_dec_source #(
  parameter int pN_MAX = 1024,
  parameter int pLLR_W = 4,
  parameter int pTAG_W = 4
) (
  input  logic                       iclk,
  input  logic                       ireset,
  input  logic                       iclkena,
  input  logic                       isop,
  input  logic                       ival,
  input  logic                       ieop,
  input  logic [pLLR_W-1:0]          idat,
  input  logic [pTAG_W-1:0]          itag,
  output logic                       ordy,
  output logic                       obusy,
  input  logic                       ifulla,
  input  logic                       iemptya,
  output logic                       owrite,
  output logic                       owfull,
  output logic [$clog2(pN_MAX)-1:0]  owaddr,
  output logic [pLLR_W-1:0]          owdat,
  output logic [pTAG_W-1:0]          owtag,
  output logic                       oerr
);

  localparam int cADDR_W = $clog2(pN_MAX);
  localparam logic [cADDR_W-1:0] cLAST = cADDR_W'(pN_MAX - 1);

  typedef enum logic [1:0] {ST_WAIT, ST_DATA, ST_PAD, ST_DROP} state_t;

  state_t              state_q, state_d;
  logic [cADDR_W-1:0]  cnt_q, cnt_d;
  logic [pTAG_W-1:0]   tag_q, tag_d;
  logic                owrite_q, owrite_d;
  logic                owfull_q, owfull_d;
  logic                oerr_q, oerr_d;
  logic [cADDR_W-1:0]  owaddr_q, owaddr_d;
  logic [pLLR_W-1:0]   owdat_q, owdat_d;
  logic                accept;
  logic                start;

  assign ordy   = ireset & (((state_q == ST_WAIT) & ~ifulla) | (state_q == ST_DATA) | (state_q == ST_DROP));
  assign obusy  = (state_q != ST_WAIT) | ~iemptya;
  assign accept = iclkena & ival & ordy;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tag_d    = tag_q;
    owrite_d = 1'b0;
    owfull_d = 1'b0;
    oerr_d   = 1'b0;
    owaddr_d = owaddr_q;
    owdat_d  = owdat_q;
    start    = 1'b0;

    case (state_q)
      ST_WAIT: begin
        if (accept && isop) start = 1'b1;
      end
      ST_DATA: begin
        if (accept) begin
          if (isop) begin
            // restart reuses the same bank from address 0
            start  = 1'b1;
            oerr_d = 1'b1;
          end else begin
            owrite_d = 1'b1;
            owaddr_d = cnt_q;
            owdat_d  = idat;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == cLAST) begin
              owfull_d = 1'b1;
              state_d  = ieop ? ST_WAIT : ST_DROP;
            end else if (ieop) begin
              state_d = ST_PAD;
            end
          end
        end
      end
      ST_PAD: begin
        if (iclkena) begin
          owrite_d = 1'b1;
          owaddr_d = cnt_q;
          owdat_d  = '0;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == cLAST) begin
            owfull_d = 1'b1;
            oerr_d   = 1'b1;
            state_d  = ST_WAIT;
          end
        end
      end
      ST_DROP: begin
        if (accept) begin
          if (isop) begin
            oerr_d = 1'b1;
            if (!ifulla) start = 1'b1;
            else         state_d = ST_WAIT;
          end else if (ieop) begin
            oerr_d  = 1'b1;
            state_d = ST_WAIT;
          end
        end
      end
      default: state_d = ST_WAIT;
    endcase

    if (start) begin
      owrite_d = 1'b1;
      owaddr_d = '0;
      owdat_d  = idat;
      tag_d    = itag;
      cnt_d    = cADDR_W'(1);
      state_d  = ieop ? ST_PAD : ST_DATA;
    end
  end

  always_ff @(posedge iclk) begin
    if (!ireset) begin
      state_q  <= ST_WAIT;
      cnt_q    <= '0;
      tag_q    <= '0;
      owrite_q <= 1'b0;
      owfull_q <= 1'b0;
      oerr_q   <= 1'b0;
      owaddr_q <= '0;
      owdat_q  <= '0;
    end else if (iclkena) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tag_q    <= tag_d;
      owrite_q <= owrite_d;
      owfull_q <= owfull_d;
      oerr_q   <= oerr_d;
      owaddr_q <= owaddr_d;
      owdat_q  <= owdat_d;
    end
  end

  assign owrite = owrite_q;
  assign owfull = owfull_q;
  assign oerr   = oerr_q;
  assign owaddr = owaddr_q;
  assign owdat  = owdat_q;
  assign owtag  = tag_q;

endmodule

// File: tb/tb_pc_3gpp_dec_source.sv
// Bench for pc_3gpp_dec_source at pN_MAX=8: frame-level model of expected buffer writes vs observed writes.
module tb_pc_3gpp_dec_source;

  localparam int N = 8;

  logic       iclk = 1'b0;
  logic       ireset, iclkena, isop, ival, ieop, ifulla, iemptya;
  logic [3:0] idat, itag;
  logic       ordy, obusy, owrite, owfull, oerr;
  logic [2:0] owaddr;
  logic [3:0] owdat, owtag;

  pc_3gpp_dec_source #(.pN_MAX(N), .pLLR_W(4), .pTAG_W(4)) dut (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .isop(isop), .ival(ival),
    .ieop(ieop), .idat(idat), .itag(itag), .ordy(ordy), .obusy(obusy),
    .ifulla(ifulla), .iemptya(iemptya), .owrite(owrite), .owfull(owfull),
    .owaddr(owaddr), .owdat(owdat), .owtag(owtag), .oerr(oerr)
  );

  always #5 iclk = ~iclk;

  typedef struct packed {
    logic       err;
    logic       full;
    logic       wr;
    logic [2:0] addr;
    logic [3:0] dat;
    logic [3:0] tag;
  } ev_t;

  ev_t        obs_q[$];
  ev_t        exp_q[$];
  logic [3:0] fd [0:15];
  int         checks = 0;
  int         failures = 0;

  // Record every effective (clock-enabled) write or error pulse.
  always @(posedge iclk) begin : mon
    logic en_l;
    ev_t  e;
    en_l = iclkena & ireset;
    #1;
    if (en_l && (owrite === 1'b1 || oerr === 1'b1)) begin
      e = '0;
      e.err  = oerr;
      e.full = owfull;
      e.wr   = owrite;
      if (owrite === 1'b1) begin
        e.addr = owaddr;
        e.dat  = owdat;
        e.tag  = owtag;
      end
      obs_q.push_back(e);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Frame-level expectation: pN_MAX writes, data then zeros, commit on the last address.
  task automatic add_expected(input int len, input logic [3:0] tag);
    ev_t e;
    for (int a = 0; a < N; a++) begin
      e      = '0;
      e.wr   = 1'b1;
      e.addr = 3'(a);
      e.dat  = (a < len) ? fd[a] : 4'd0;
      e.tag  = tag;
      e.full = (a == N - 1);
      e.err  = (a == N - 1) && (len < N);
      exp_q.push_back(e);
    end
    if (len > N) begin
      e     = '0;
      e.err = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  task automatic fill_seq(input int len);
    for (int i = 0; i < 16; i++) fd[i] = 4'(i + 1);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 16; i++) fd[i] = 4'($urandom);
  endtask

  // Called at a negedge; cem: 0 = enable high, 1 = toggle, 2 = random.
  task automatic send_frame(input int count, input int eop_at, input logic [3:0] tag,
                            input int gap, input int cem);
    int i = 0;
    int guard = 0;
    while (i < count && guard < 500) begin
      iclkena = (cem == 0) ? 1'b1 : (cem == 1) ? ~iclkena : 1'($urandom_range(0, 1));
      ival    = ($urandom_range(0, 99) >= gap);
      isop    = (i == 0);
      ieop    = (i == eop_at);
      idat    = fd[i];
      itag    = (i == 0) ? tag : 4'($urandom);
      #1;
      if (ival && ordy && iclkena) i++;
      @(posedge iclk);
      @(negedge iclk);
      guard++;
    end
    ival = 1'b0; isop = 1'b0; ieop = 1'b0;
    checks++;
    if (i != count) begin
      failures++;
      $display("FAIL send_frame_timeout accepted=%0d required=%0d", i, count);
    end
  endtask

  task automatic wait_idle(input int cem);
    int guard = 0;
    logic idle = 1'b0;
    while (!idle && guard < 200) begin
      iclkena = (cem == 0) ? 1'b1 : (cem == 1) ? ~iclkena : 1'($urandom_range(0, 1));
      #1;
      if (obusy === 1'b0) idle = 1'b1;
      else begin
        @(posedge iclk);
        @(negedge iclk);
        guard++;
      end
    end
    iclkena = 1'b1;
    checks++;
    if (!idle) begin
      failures++;
      $display("FAIL wait_idle_timeout obusy=%b required=0", obusy);
    end
  endtask

  task automatic test_reset();
    ireset = 1'b0; iclkena = 1'b1; isop = 0; ival = 0; ieop = 0; idat = 0; itag = 0;
    ifulla = 1'b0; iemptya = 1'b1;
    repeat (3) @(posedge iclk);
    #1;
    checks++;
    if ({owrite, owfull, oerr, owaddr, owdat, owtag, ordy} !== 16'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h required=0", {owrite, owfull, oerr, owaddr, owdat, owtag, ordy});
    end
    @(negedge iclk);
    ireset = 1'b1;
    #1;
    checks++;
    if (ordy !== 1'b1 || obusy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release ordy=%b obusy=%b required ordy=1 obusy=0", ordy, obusy);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_full_frame();
    fill_seq(8);
    add_expected(8, 4'd5);
    send_frame(8, 7, 4'd5, 0, 0);
    wait_idle(0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL full_count got=%0d required=%0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        failures++;
        $display("FAIL full_ev%0d got=%h required=%h", k, obs_q[k], exp_q[k]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_short_frame();
    fill_seq(5);
    add_expected(5, 4'd9);
    send_frame(5, 4, 4'd9, 0, 0);
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (ordy !== 1'b0) begin
        failures++;
        $display("FAIL short_pad_ordy%0d got=%b required=0", k, ordy);
      end
      @(posedge iclk);
      @(negedge iclk);
    end
    #1;
    checks++;
    if (ordy !== 1'b1) begin
      failures++;
      $display("FAIL short_back_to_wait ordy=%b required=1", ordy);
    end
    wait_idle(0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL short_count got=%0d required=%0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        failures++;
        $display("FAIL short_ev%0d got=%h required=%h", k, obs_q[k], exp_q[k]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_long_frame();
    fill_seq(11);
    add_expected(11, 4'd3);
    send_frame(11, 10, 4'd3, 0, 0);
    wait_idle(0);
    fill_rand();
    add_expected(8, 4'd12);
    send_frame(8, 7, 4'd12, 20, 0);
    wait_idle(0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL long_count got=%0d required=%0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        failures++;
        $display("FAIL long_ev%0d got=%h required=%h", k, obs_q[k], exp_q[k]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_fulla();
    fill_rand();
    ifulla = 1'b1; iemptya = 1'b0; iclkena = 1'b1;
    isop = 1'b1; ival = 1'b1; ieop = 1'b0; idat = fd[0]; itag = 4'd7;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (ordy !== 1'b0 || obusy !== 1'b1) begin
        failures++;
        $display("FAIL fulla_block%0d ordy=%b obusy=%b required ordy=0 obusy=1", k, ordy, obusy);
      end
      @(posedge iclk);
      @(negedge iclk);
    end
    ifulla = 1'b0;
    #1;
    checks++;
    if (ordy !== 1'b1 || obs_q.size() != 0) begin
      failures++;
      $display("FAIL fulla_release ordy=%b writes=%0d required ordy=1 writes=0", ordy, obs_q.size());
    end
    add_expected(8, 4'd7);
    send_frame(8, 7, 4'd7, 0, 0);
    #1;
    checks++;
    if (obusy !== 1'b1) begin
      failures++;
      $display("FAIL fulla_busy_nonempty got=%b required=1", obusy);
    end
    iemptya = 1'b1;
    wait_idle(0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL fulla_count got=%0d required=%0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        failures++;
        $display("FAIL fulla_ev%0d got=%h required=%h", k, obs_q[k], exp_q[k]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_clkena();
    fill_seq(8);
    add_expected(8, 4'd5);
    send_frame(8, 7, 4'd5, 0, 1);
    wait_idle(1);
    fill_seq(5);
    add_expected(5, 4'd9);
    send_frame(5, 4, 4'd9, 0, 0);
    wait_idle(1);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL clkena_count got=%0d required=%0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        failures++;
        $display("FAIL clkena_ev%0d got=%h required=%h", k, obs_q[k], exp_q[k]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_midreset();
    ev_t e;
    fill_rand();
    for (int a = 0; a < 3; a++) begin
      e = '0; e.wr = 1'b1; e.addr = 3'(a); e.dat = fd[a]; e.tag = 4'd6;
      exp_q.push_back(e);
    end
    send_frame(3, 99, 4'd6, 0, 0);
    ireset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge iclk);
      #1;
      checks++;
      if ({owrite, owfull, oerr, owaddr, owdat, owtag, ordy} !== 16'd0) begin
        failures++;
        $display("FAIL midreset_outputs%0d got=%h required=0", k, {owrite, owfull, oerr, owaddr, owdat, owtag, ordy});
      end
      @(negedge iclk);
    end
    ireset = 1'b1;
    fill_rand();
    add_expected(8, 4'd11);
    send_frame(8, 7, 4'd11, 0, 0);
    wait_idle(0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL midreset_count got=%0d required=%0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        failures++;
        $display("FAIL midreset_ev%0d got=%h required=%h", k, obs_q[k], exp_q[k]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    int len;
    logic [3:0] tag;
    for (int f = 0; f < 8; f++) begin
      // a stray sample outside a frame must be ignored
      iclkena = 1'b1; ival = 1'b1; isop = 1'b0; ieop = 1'($urandom_range(0, 1)); idat = 4'($urandom);
      @(posedge iclk);
      @(negedge iclk);
      ival = 1'b0; ieop = 1'b0;
      fill_rand();
      len = $urandom_range(1, 12);
      tag = 4'($urandom);
      add_expected(len, tag);
      send_frame(len, len - 1, tag, $urandom_range(0, 40), 2);
      wait_idle(2);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL random_count got=%0d required=%0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        failures++;
        $display("FAIL random_ev%0d got=%h required=%h", k, obs_q[k], exp_q[k]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_short_frame();
    test_long_frame();
    test_fulla();
    test_clkena();
    test_midreset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
